// File: rtl/datapath_controller.sv
// datapath_controller
//
// Instruction-sequencing FSM for the 16-bit register-file/ALU datapath.
// It accepts one instruction per start strobe, decodes it, and steps the
// datapath through read-A, read-B, ALU and write-back cycles. All datapath
// controls are Moore outputs derived from the current state and the latched
// instruction register (IR).
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   s            in   start strobe, sampled only while idle (WAIT)
//   instr        in   instruction, latched on the edge that accepts s
//   readnum      out  register-file read index
//   writenum     out  register-file write index
//   write        out  register-file write enable
//   vsel         out  write-data select (1 = datapath_in, 0 = C)
//   loada        out  load A register
//   loadb        out  load B register
//   loadc        out  load C register
//   loads        out  load status register
//   asel         out  1 = A operand forced to 0
//   bsel         out  always 0
//   shift        out  B-path shifter control
//   ALUop        out  ALU function
//   datapath_in  out  sign-extended imm8 (only non-zero in WRITE_IMM)
//   w            out  idle, ready for s
//   err          out  last accepted instruction was illegal

module datapath_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in,
    output logic        w,
    output logic        err
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg,
        StWriteImm
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q;
    logic        err_q;

    // Instruction fields
    logic [2:0] opc;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic [7:0] imm8;

    assign opc  = ir_q[15:13];
    assign op   = ir_q[12:11];
    assign rn   = ir_q[10:8];
    assign rd   = ir_q[7:5];
    assign sh   = ir_q[4:3];
    assign rm   = ir_q[2:0];
    assign imm8 = ir_q[7:0];

    // Decode
    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_legal;

    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    assign is_alu     = (opc == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    logic accept;
    assign accept = (state_q == StWait) && s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            ir_q    <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q  <= instr;
                err_q <= 1'b0;
            end else if ((state_q == StDecode) && !is_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        readnum     = 3'd0;
        writenum    = 3'd0;
        write       = 1'b0;
        vsel        = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = 2'b00;
        ALUop       = 2'b00;
        datapath_in = 16'h0000;
        w           = 1'b0;

        unique case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) state_d = StDecode;
            end
            StDecode: begin
                if (is_mov_imm)               state_d = StWriteImm;
                else if (is_mov_reg || is_mvn) state_d = StGetB;
                else if (is_alu)              state_d = StGetA;
                else                          state_d = StWait;
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                shift   = sh;
                loadb   = 1'b1;
                state_d = StAlu;
            end
            StAlu: begin
                ALUop = is_mov_reg ? 2'b00 : op;
                // MOV reg and MVN pass B through, so A is zeroed
                asel  = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = StWait;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWriteReg;
                end
            end
            StWriteReg: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = StWait;
            end
            StWriteImm: begin
                vsel        = 1'b1;
                datapath_in = {{8{imm8[7]}}, imm8};
                writenum    = rn;
                write       = 1'b1;
                state_d     = StWait;
            end
            default: state_d = StWait;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;

    logic        clk;
    logic        reset_n;
    logic        s;
    logic [15:0] instr;
    logic [2:0]  readnum, writenum;
    logic        write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic        w, err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    datapath_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s           (s),
        .instr       (instr),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .datapath_in (datapath_in),
        .w           (w),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write pulses counted once per cycle, away from the active edge
    always @(negedge clk) if (write === 1'b1) wr_cnt++;

    // Packed view of all outputs:
    // {readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
    //  shift, ALUop, datapath_in, w, err}
    logic [35:0] obs;
    assign obs = {readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                  shift, ALUop, datapath_in, w, err};

    function automatic logic [35:0] mk(input logic [2:0] rn, input logic [2:0] wn,
                                       input logic wr, input logic vs, input logic la,
                                       input logic lb, input logic lc, input logic ls,
                                       input logic as, input logic [1:0] sh,
                                       input logic [1:0] op, input logic [15:0] din,
                                       input logic wi, input logic er);
        return {rn, wn, wr, vs, la, lb, lc, ls, as, 1'b0, sh, op, din, wi, er};
    endfunction

    logic [35:0] idle_v, busy_v;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present s/instr for one edge (edge 0), then scramble instr
    task automatic start(input logic [15:0] ins);
        s     = 1'b1;
        instr = ins;
        step();
        s     = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s       = 1'b0;
        instr   = 16'h0000;
        #12;
        n_checks++;
        if (obs !== idle_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, idle_v);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (obs !== idle_v) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h want %h", obs, idle_v);
        end
    endtask

    task automatic test_mov_imm();
        logic [35:0] e [0:2];
        int w0;
        e[0] = busy_v;
        e[1] = mk(0, 3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'hFFFB, 0, 0);
        e[2] = idle_v;
        w0 = wr_cnt;
        start(16'hD3FB);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL mov_imm edge%0d: got %h want %h", i, obs, e[i]);
            end
        end
        n_checks++;
        if (wr_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL mov_imm write_pulses: got %0d want 1", wr_cnt - w0);
        end
    endtask

    task automatic test_add();
        logic [35:0] e [0:5];
        e[0] = busy_v;
        e[1] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 16'h0, 0, 0);
        e[3] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[4] = mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[5] = idle_v;
        start(16'hA148);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL add edge%0d: got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    // s pulses with a different instruction during busy cycles must be ignored
    task automatic test_cmp();
        logic [35:0] e [0:4];
        int w0;
        e[0] = busy_v;
        e[1] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 16'h0, 0, 0);
        e[4] = idle_v;
        w0 = wr_cnt;
        start(16'hA900);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            s     = (i == 0 || i == 2);
            instr = 16'hD3FB;
            if (i == 3) s = 1'b0;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL cmp edge%0d: got %h want %h", i, obs, e[i]);
            end
        end
        s = 1'b0;
        n_checks++;
        if (wr_cnt - w0 !== 0) begin
            n_fail++;
            $display("FAIL cmp write_pulses: got %0d want 0", wr_cnt - w0);
        end
    endtask

    task automatic test_mvn();
        logic [35:0] e [0:4];
        e[0] = busy_v;
        e[1] = mk(7, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b11, 16'h0, 0, 0);
        e[3] = mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[4] = idle_v;
        start(16'hB887);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL mvn edge%0d: got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_mov_reg();
        logic [35:0] e [0:4];
        e[0] = busy_v;
        e[1] = mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 16'h0, 0, 0);
        e[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 16'h0, 0, 0);
        e[3] = mk(0, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        e[4] = idle_v;
        start(16'hC0B2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL mov_reg edge%0d: got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_illegal(input logic [15:0] ins);
        logic [35:0] err_idle;
        err_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 1, 1);
        start(ins);
        n_checks++;
        if (obs !== busy_v) begin
            n_fail++;
            $display("FAIL illegal_%h decode: got %h want %h", ins, obs, busy_v);
        end
        step();
        n_checks++;
        if (obs !== err_idle) begin
            n_fail++;
            $display("FAIL illegal_%h err_idle: got %h want %h", ins, obs, err_idle);
        end
        step();
        n_checks++;
        if (obs !== err_idle) begin
            n_fail++;
            $display("FAIL illegal_%h err_held: got %h want %h", ins, obs, err_idle);
        end
        // Next legal instruction clears err on its acceptance edge
        test_mov_imm();
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        start(16'hA148);
        step();
        step();
        n_checks++;
        if (obs !== mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 16'h0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid get_b: got %h", obs);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== idle_v) begin
            n_fail++;
            $display("FAIL reset_mid immediate: got %h want %h", obs, idle_v);
        end
        step();
        step();
        n_checks++;
        if (obs !== idle_v) begin
            n_fail++;
            $display("FAIL reset_mid held: got %h want %h", obs, idle_v);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (wr_cnt - w0 !== 0) begin
            n_fail++;
            $display("FAIL reset_mid write_pulses: got %0d want 0", wr_cnt - w0);
        end
        test_add();
    endtask

    // s held high: the next instruction starts on the first edge back in WAIT
    task automatic test_back_to_back();
        logic [35:0] e_imm1, e_imm2;
        e_imm1 = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0007, 0, 0);
        e_imm2 = mk(0, 2, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'hFF80, 0, 0);
        s     = 1'b1;
        instr = 16'hD107;
        step();
        n_checks++;
        if (obs !== busy_v) begin
            n_fail++;
            $display("FAIL b2b decode1: got %h want %h", obs, busy_v);
        end
        instr = 16'hD280;
        step();
        n_checks++;
        if (obs !== e_imm1) begin
            n_fail++;
            $display("FAIL b2b write1: got %h want %h", obs, e_imm1);
        end
        step();
        n_checks++;
        if (obs !== idle_v) begin
            n_fail++;
            $display("FAIL b2b wait: got %h want %h", obs, idle_v);
        end
        step();
        s = 1'b0;
        n_checks++;
        if (obs !== busy_v) begin
            n_fail++;
            $display("FAIL b2b decode2: got %h want %h", obs, busy_v);
        end
        step();
        n_checks++;
        if (obs !== e_imm2) begin
            n_fail++;
            $display("FAIL b2b write2: got %h want %h", obs, e_imm2);
        end
        step();
        n_checks++;
        if (obs !== idle_v) begin
            n_fail++;
            $display("FAIL b2b final: got %h want %h", obs, idle_v);
        end
    endtask

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 1, 0);
        busy_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0, 0, 0);
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_mvn();
        test_mov_reg();
        test_illegal(16'hE000);
        test_illegal(16'h0000);
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

endmodule
